food_dispense_timer: RTL and testbench
======================================

// Module: food_dispense_timer
// PURPOSE
// - Multi-bowl successor to the single-channel food timer. Each of NUM_CH channels runs a
//   programmable dispense window (motor on), then a programmable cooldown lockout.
// - Per-channel abort and bowl-full sensing. Done/aborted pulses go to the feeder controller.
// - Sits between the feeder control FSM (start/abort) and the motor drivers (motor_on).
// PARAMETERS
// - NUM_CH   4  number of independent bowl/motor channels
// - CNT_W    8  counter width; dispense and cooldown durations are 0..2^CNT_W-1 cycles
// PORTS
// - clock            in   1             system clock, rising edge
// - reset            in   1             asynchronous, active-high; clears all state
// - start            in   NUM_CH        per-channel dispense request; level sampled each cycle
// - abort            in   NUM_CH        per-channel synchronous abort/clear
// - full_sensor      in   NUM_CH        per-channel bowl-full; terminates dispensing
// - dispense_time    in   CNT_W         dispense duration in cycles; shared by all channels
// - cooldown_time    in   CNT_W         lockout after dispense in cycles; shared by all channels
// - motor_on         out  NUM_CH        motor enable, registered
// - busy             out  NUM_CH        1 while the channel is in DISPENSE or COOLDOWN
// - done             out  NUM_CH        1-cycle pulse: dispense completed full duration
// - aborted          out  NUM_CH        1-cycle pulse: dispense cut short (abort or full)
// - count_out        out  NUM_CH*CNT_W  per-channel counter; ch i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
// - Reset: state IDLE; motor_on, busy, done, aborted = 0; all counts = 0; latched times = 0.
// - Outputs are registered. Channels are fully independent; no shared arbitration.
// - States per channel: IDLE, DISPENSE, COOLDOWN.
// - Latching: on IDLE->DISPENSE, latch T = max(dispense_time, 1) and C = cooldown_time.
//   Later changes to dispense_time/cooldown_time do not affect a running cycle.
// - IDLE:
//   - start=1, abort=0, full_sensor=0 -> DISPENSE; count=0; motor_on=1 and busy=1 next cycle.
//   - start with abort=1 or full_sensor=1 is ignored (no pulse).
// - DISPENSE: count +1 per cycle; motor_on high for exactly T cycles.
//   - count==T-1 -> done=1 for 1 cycle; motor_on=0. C>0: COOLDOWN, count=0. C==0: IDLE, count=0.
//   - abort=1 (highest priority) -> IDLE, count=0, motor_on=0, aborted=1 for 1 cycle.
//   - full_sensor=1 (abort=0) -> motor_on=0, aborted=1 for 1 cycle, then COOLDOWN (if C>0)
//     or IDLE (C==0); count=0.
//   - If the final cycle coincides with abort/full, abort/full wins; done is not asserted.
// - COOLDOWN: motor_on=0, busy=1; count +1 per cycle; count==C-1 -> IDLE, count=0.
//   - abort=1 -> IDLE immediately, count=0, no pulse. full_sensor has no effect.
//   - start is ignored; a level-held start re-triggers on the first cycle back in IDLE.
// - IDLE count_out holds 0; counters never wrap (terminal compare precedes max value).
// - done and aborted are never high together on a channel; each lasts exactly 1 cycle.
// - Async reset mid-operation: motor_on drops immediately; no done/aborted pulse emitted.
// TESTING
// - ch0, T=5, C=3, 1-cycle start pulse -> motor_on high 5 cycles; done 1 cycle;
//   busy high 8 cycles total; count_out 0..4 then 0..2; back to IDLE.
// - T=10, full_sensor[1] asserted on 4th DISPENSE cycle -> motor_on[1] low next edge,
//   aborted[1]=1 for 1 cycle, done[1] stays 0, then COOLDOWN of C cycles.
// - T=10, C=4, abort[2] during DISPENSE count=6 -> IDLE, aborted pulse;
//   abort during COOLDOWN -> IDLE, no pulse.
// - dispense_time=0 -> motor_on 1 cycle; cooldown_time=0 -> busy drops right after done;
//   start held high -> back-to-back cycles.
// - All 4 channels started on different cycles with T changed mid-run -> each uses its latched T;
//   start+abort same cycle in IDLE -> no activity.
// - Async reset pulse mid-DISPENSE on all channels -> all outputs 0 before next clock edge;
//   count_out=0.

Source files
------------

// File: rtl/food_dispense_timer.sv
// ----------------------------------------------------------------------------
// food_dispense_timer
//
// Multi-bowl feeder timer. Each of NUM_CH independent channels runs a
// dispense window (motor on) of T cycles followed by a cooldown lockout of
// C cycles. T and C are captured when the channel leaves IDLE, so the feeder
// controller may reprogram the shared duration inputs while channels run.
//
// Interface semantics: start is a level, not a handshake. A channel in IDLE
// accepts it on any cycle where abort and full_sensor are both low. While
// the channel is busy, start is simply not looked at. There is no
// backpressure anywhere in this block.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high; clears all state
//   start          in   [NUM_CH]  per-channel dispense request (level)
//   abort          in   [NUM_CH]  per-channel synchronous abort/clear
//   full_sensor    in   [NUM_CH]  per-channel bowl-full; ends dispensing
//   dispense_time  in   [CNT_W]   dispense duration, shared (0 acts as 1)
//   cooldown_time  in   [CNT_W]   lockout after dispense, shared
//   motor_on       out  [NUM_CH]  motor enable
//   busy           out  [NUM_CH]  channel is in DISPENSE or COOLDOWN
//   done           out  [NUM_CH]  1-cycle pulse: full-length dispense
//   aborted        out  [NUM_CH]  1-cycle pulse: dispense cut short
//   count_out      out  [NUM_CH*CNT_W] per-channel counter, ch i at
//                                 [i*CNT_W +: CNT_W]
//   dbg_state      out  [NUM_CH*2] per-channel FSM state, ch i at [i*2 +: 2]
//                                 (0 IDLE, 1 DISPENSE, 2 COOLDOWN)
// ----------------------------------------------------------------------------
module food_dispense_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH-1:0]       full_sensor,
  input  logic [CNT_W-1:0]        dispense_time,
  input  logic [CNT_W-1:0]        cooldown_time,
  output logic [NUM_CH-1:0]       motor_on,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       aborted,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH*2-1:0]     dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_t, w_t_nxt;
    logic [CNT_W-1:0] r_c, w_c_nxt;
    logic             r_done, w_done_nxt;
    logic             r_aborted, w_aborted_nxt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_state   <= S_IDLE;
        r_count   <= CNT_ZERO;
        r_t       <= CNT_ZERO;
        r_c       <= CNT_ZERO;
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_count   <= w_count_nxt;
        r_t       <= w_t_nxt;
        r_c       <= w_c_nxt;
        r_done    <= w_done_nxt;
        r_aborted <= w_aborted_nxt;
      end
    end

    // The counter defaults to zero: every state exit clears it, and it only
    // advances while a window is still running. The terminal compare fires
    // at T-1 / C-1, so the counter can never reach its max value and wrap.
    always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = CNT_ZERO;
      w_t_nxt       = r_t;
      w_c_nxt       = r_c;
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start[g] && !abort[g] && !full_sensor[g]) begin
            w_state_nxt = S_DISPENSE;
            // A zero duration still runs the motor for one cycle.
            w_t_nxt     = (dispense_time == CNT_ZERO) ? CNT_ONE : dispense_time;
            w_c_nxt     = cooldown_time;
          end
        end
        S_DISPENSE: begin
          // abort beats full_sensor, and both beat the final-cycle done.
          if (abort[g]) begin
            w_state_nxt   = S_IDLE;
            w_aborted_nxt = 1'b1;
          end else if (full_sensor[g]) begin
            w_state_nxt   = (r_c != CNT_ZERO) ? S_COOLDOWN : S_IDLE;
            w_aborted_nxt = 1'b1;
          end else if (r_count == r_t - CNT_ONE) begin
            w_state_nxt = (r_c != CNT_ZERO) ? S_COOLDOWN : S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_count_nxt = r_count + CNT_ONE;
          end
        end
        S_COOLDOWN: begin
          // COOLDOWN is only entered with C > 0, so C-1 does not underflow.
          if (abort[g] || (r_count == r_c - CNT_ONE)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_count_nxt = r_count + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // motor_on and busy are decoded straight from the state flop, so they
    // switch on clock edges and drop the moment reset is asserted.
    assign motor_on[g]                   = (r_state == S_DISPENSE);
    assign busy[g]                       = (r_state != S_IDLE);
    assign done[g]                       = r_done;
    assign aborted[g]                    = r_aborted;
    assign count_out[g*CNT_W +: CNT_W]   = r_count;
    assign dbg_state[g*2 +: 2]           = r_state;
  end

endmodule

// File: tb/tb_food_dispense_timer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_food_dispense_timer
//
// Directed bench for food_dispense_timer. A per-channel reference model
// tracks "cycles of motor left" and "cycles of cooldown left" and derives
// every output from those two numbers. Each cycle, every output is checked
// against the model on the falling edge. Per-test activity totals, and the
// ch0 count trace, are also checked against hand-computed literals.
// ----------------------------------------------------------------------------
module tb_food_dispense_timer;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NUM_CH-1:0]       start, abort, full_sensor;
  logic [CNT_W-1:0]        dispense_time, cooldown_time;
  logic [NUM_CH-1:0]       motor_on, busy, done, aborted;
  logic [NUM_CH*CNT_W-1:0] count_out;
  logic [NUM_CH*2-1:0]     dbg_state;

  food_dispense_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .full_sensor   (full_sensor),
    .dispense_time (dispense_time),
    .cooldown_time (cooldown_time),
    .motor_on      (motor_on),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .count_out     (count_out),
    .dbg_state     (dbg_state)
  );

  // ---------------- reference model ----------------
  int   m_left_d [NUM_CH];
  int   m_left_c [NUM_CH];
  int   m_t      [NUM_CH];
  int   m_c      [NUM_CH];
  logic m_done   [NUM_CH];
  logic m_abt    [NUM_CH];

  always @(posedge clock or posedge reset) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (reset) begin
        m_left_d[ch] = 0;
        m_left_c[ch] = 0;
        m_t[ch]      = 0;
        m_c[ch]      = 0;
        m_done[ch]   = 1'b0;
        m_abt[ch]    = 1'b0;
      end else begin
        m_done[ch] = 1'b0;
        m_abt[ch]  = 1'b0;
        if (m_left_d[ch] > 0) begin
          if (abort[ch]) begin
            m_left_d[ch] = 0;
            m_abt[ch]    = 1'b1;
          end else if (full_sensor[ch]) begin
            m_left_d[ch] = 0;
            m_abt[ch]    = 1'b1;
            m_left_c[ch] = m_c[ch];
          end else if (m_left_d[ch] == 1) begin
            m_left_d[ch] = 0;
            m_done[ch]   = 1'b1;
            m_left_c[ch] = m_c[ch];
          end else begin
            m_left_d[ch] = m_left_d[ch] - 1;
          end
        end else if (m_left_c[ch] > 0) begin
          if (abort[ch] || m_left_c[ch] == 1) m_left_c[ch] = 0;
          else m_left_c[ch] = m_left_c[ch] - 1;
        end else if (start[ch] && !abort[ch] && !full_sensor[ch]) begin
          m_t[ch]      = (dispense_time == 0) ? 1 : int'(dispense_time);
          m_c[ch]      = int'(cooldown_time);
          m_left_d[ch] = m_t[ch];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;
  int s_motor [NUM_CH], s_busy [NUM_CH], s_done [NUM_CH], s_abt [NUM_CH];
  int sm_motor[NUM_CH], sm_busy[NUM_CH], sm_done[NUM_CH], sm_abt[NUM_CH];
  int b_motor [NUM_CH], b_busy [NUM_CH], b_done [NUM_CH], b_abt [NUM_CH];
  int bm_motor[NUM_CH], bm_busy[NUM_CH], bm_done[NUM_CH], bm_abt[NUM_CH];
  logic             trace_en;
  logic [CNT_W-1:0] trace_q[$];
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0]       e_motor, e_busy, e_done, e_abt;
    logic [NUM_CH*CNT_W-1:0] e_cnt;
    int v;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_motor[ch] = (m_left_d[ch] > 0);
      e_busy[ch]  = (m_left_d[ch] > 0) || (m_left_c[ch] > 0);
      e_done[ch]  = m_done[ch];
      e_abt[ch]   = m_abt[ch];
      if (m_left_d[ch] > 0)      v = m_t[ch] - m_left_d[ch];
      else if (m_left_c[ch] > 0) v = m_c[ch] - m_left_c[ch];
      else                       v = 0;
      e_cnt[ch*CNT_W +: CNT_W] = v[CNT_W-1:0];
    end
    check("motor_on",  longint'(motor_on),  longint'(e_motor));
    check("busy",      longint'(busy),      longint'(e_busy));
    check("done",      longint'(done),      longint'(e_done));
    check("aborted",   longint'(aborted),   longint'(e_abt));
    check("count_out", longint'(count_out), longint'(e_cnt));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      s_motor[ch]  += int'(motor_on[ch]);
      s_busy[ch]   += int'(busy[ch]);
      s_done[ch]   += int'(done[ch]);
      s_abt[ch]    += int'(aborted[ch]);
      sm_motor[ch] += int'(e_motor[ch]);
      sm_busy[ch]  += int'(e_busy[ch]);
      sm_done[ch]  += int'(e_done[ch]);
      sm_abt[ch]   += int'(e_abt[ch]);
    end
    if (trace_en && busy[0]) trace_q.push_back(count_out[CNT_W-1:0]);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: compare on the falling edge, then return just after the next
  // rising edge so the caller can change inputs for the following edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      compare_all();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      b_motor[ch]  = s_motor[ch];  b_busy[ch]  = s_busy[ch];
      b_done[ch]   = s_done[ch];   b_abt[ch]   = s_abt[ch];
      bm_motor[ch] = sm_motor[ch]; bm_busy[ch] = sm_busy[ch];
      bm_done[ch]  = sm_done[ch];  bm_abt[ch]  = sm_abt[ch];
    end
  endtask

  // Activity since the last snap(), for both the DUT and the model.
  task automatic check_ch(input string tag, input int ch, input int e_mot,
                          input int e_bsy, input int e_dn, input int e_ab);
    check($sformatf("%s_ch%0d_motor_cycles", tag, ch), s_motor[ch] - b_motor[ch], e_mot);
    check($sformatf("%s_ch%0d_busy_cycles", tag, ch),  s_busy[ch] - b_busy[ch],   e_bsy);
    check($sformatf("%s_ch%0d_done_pulses", tag, ch),  s_done[ch] - b_done[ch],   e_dn);
    check($sformatf("%s_ch%0d_abort_pulses", tag, ch), s_abt[ch] - b_abt[ch],     e_ab);
    check($sformatf("%s_ch%0d_model_motor", tag, ch),  sm_motor[ch] - bm_motor[ch], e_mot);
    check($sformatf("%s_ch%0d_model_busy", tag, ch),   sm_busy[ch] - bm_busy[ch],   e_bsy);
    check($sformatf("%s_ch%0d_model_done", tag, ch),   sm_done[ch] - bm_done[ch],   e_dn);
    check($sformatf("%s_ch%0d_model_abort", tag, ch),  sm_abt[ch] - bm_abt[ch],     e_ab);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    start         = '0;
    abort         = '0;
    full_sensor   = '0;
    dispense_time = '0;
    cooldown_time = '0;
    n_cmp         = 0;
    n_err         = 0;
    trace_en      = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      s_motor[ch] = 0; s_busy[ch] = 0; s_done[ch] = 0; s_abt[ch] = 0;
      sm_motor[ch] = 0; sm_busy[ch] = 0; sm_done[ch] = 0; sm_abt[ch] = 0;
    end
    snap();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_motor_on",  longint'(motor_on),  0);
    check("reset_busy",      longint'(busy),      0);
    check("reset_done",      longint'(done),      0);
    check("reset_aborted",   longint'(aborted),   0);
    check("reset_count_out", longint'(count_out), 0);
    @(negedge clock);
    compare_all();
    reset = 1'b0;
    @(posedge clock);
    #1;
    tick(2);

    // T1: ch0, T=5, C=3, one-cycle start
    snap();
    trace_en      = 1'b1;
    dispense_time = 8'd5;
    cooldown_time = 8'd3;
    start         = 4'b0001;
    tick();
    start = '0;
    tick(12);
    trace_en = 1'b0;
    check_ch("t1", 0, 5, 8, 1, 0);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2};
    check("t1_trace_len", trace_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < trace_q.size())
        check($sformatf("t1_trace_%0d", i), longint'(trace_q[i]), longint'(exp_q[i]));
    end

    // T2: ch1, T=10, C=3, full on the 4th dispense cycle
    snap();
    dispense_time = 8'd10;
    cooldown_time = 8'd3;
    start         = 4'b0010;
    tick();
    start = '0;
    tick(3);
    full_sensor = 4'b0010;
    tick();
    full_sensor = '0;
    tick(8);
    check_ch("t2", 1, 4, 7, 0, 1);

    // T3a: ch2, T=10, C=4, abort while count==6
    snap();
    dispense_time = 8'd10;
    cooldown_time = 8'd4;
    start         = 4'b0100;
    tick();
    start = '0;
    tick(6);
    abort = 4'b0100;
    tick();
    abort = '0;
    tick(3);
    check_ch("t3a", 2, 7, 7, 0, 1);

    // T3b: ch2, abort during cooldown -> silent return to IDLE
    snap();
    start = 4'b0100;
    tick();
    start = '0;
    tick(11);
    abort = 4'b0100;
    tick();
    abort = '0;
    tick(3);
    check_ch("t3b", 2, 10, 12, 1, 0);

    // T4a: ch3, dispense_time=0 and cooldown_time=0
    snap();
    dispense_time = 8'd0;
    cooldown_time = 8'd0;
    start         = 4'b1000;
    tick();
    start = '0;
    tick(4);
    check_ch("t4a", 3, 1, 1, 1, 0);

    // T4b: ch0, start held high, T=2, C=1 -> two back-to-back runs
    snap();
    dispense_time = 8'd2;
    cooldown_time = 8'd1;
    start         = 4'b0001;
    tick(8);
    start = '0;
    tick(4);
    check_ch("t4b", 0, 4, 6, 2, 0);

    // T5: staggered starts, durations changed mid-run, refused starts on ch3
    snap();
    cooldown_time = 8'd2;
    dispense_time = 8'd6;
    start         = 4'b0001;
    tick();
    dispense_time = 8'd3;
    start         = 4'b0010;
    tick();
    dispense_time = 8'd9;
    start         = 4'b0100;
    tick();
    start = 4'b1000;
    abort = 4'b1000;
    tick();
    abort       = '0;
    full_sensor = 4'b1000;
    tick();
    full_sensor   = '0;
    dispense_time = 8'd4;
    cooldown_time = 8'd7;
    start         = 4'b1000;
    tick();
    start         = '0;
    dispense_time = 8'd200;
    cooldown_time = 8'd200;
    tick(25);
    check_ch("t5", 0, 6, 8, 1, 0);
    check_ch("t5", 1, 3, 5, 1, 0);
    check_ch("t5", 2, 9, 11, 1, 0);
    check_ch("t5", 3, 4, 11, 1, 0);

    // T6: asynchronous reset in the middle of dispensing on all channels
    snap();
    dispense_time = 8'd20;
    cooldown_time = 8'd5;
    start         = 4'b1111;
    tick();
    start = '0;
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_motor_on",  longint'(motor_on),  0);
    check("t6_async_busy",      longint'(busy),      0);
    check("t6_async_done",      longint'(done),      0);
    check("t6_async_aborted",   longint'(aborted),   0);
    check("t6_async_count_out", longint'(count_out), 0);
    @(negedge clock);
    compare_all();
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    snap();
    tick(30);
    for (int ch = 0; ch < NUM_CH; ch++) check_ch("t6", ch, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
